ysyx_22040175_ifu: RTL

Parametrised instruction fetch unit that replaces the single-cycle combinational fetch path (pc register, next-pc mux and direct memory read) with a pipelined, handshaked front end. It generates sequential fetch addresses, issues requests on a valid/ready memory port, and tolerates multi-cycle in-order memory latency with up to `DEPTH` requests outstanding. Returned instructions are buffered in a FIFO for the decode stage. Branch/jump redirects flush buffered and in-flight instructions.

---
 rtl/ysyx_22040175_ifu_pkg.sv | 9 +
 rtl/ysyx_22040175_ifu_fifo.sv | 60 ++++++
 rtl/ysyx_22040175_ifu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040175_ifu_pkg.sv
// Shared constants for the ysyx_22040175 instruction fetch unit: datapath widths and reset vector.
package ysyx_22040175_ifu_pkg;

    localparam int          CPU_WIDTH        = 64;
    localparam int          INST_WIDTH       = 32;
    localparam int          IFU_DEPTH        = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040175_ifu_fifo.sv
// Synchronous DEPTH-entry FIFO with flush and occupancy count; storage is cleared on reset so
// the head reads as zero until the first push.
module ysyx_22040175_ifu_fifo
    import ysyx_22040175_ifu_pkg::*;
#(
    parameter int WIDTH = INST_WIDTH,
    parameter int DEPTH = IFU_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (cnt != FULL_CNT);
    assign do_pop  = pop && !flush && (cnt != '0);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Flush only rewinds the pointers; stale storage is masked by the zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_22040175_ifu.sv
// Pipelined instruction fetch front end with credit-limited outstanding requests and redirect flush.
// Optional error path enabled by defining YSYX_22040175_IFU_FAULT_EN (adds resp_err / inst_fault).
module ysyx_22040175_ifu
    import ysyx_22040175_ifu_pkg::*;
#(
    parameter int              XLEN     = CPU_WIDTH,
    parameter int              DEPTH    = IFU_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [XLEN-1:0]       req_addr,
    input  logic                  resp_valid,
    input  logic [INST_WIDTH-1:0] resp_data,
`ifdef YSYX_22040175_IFU_FAULT_EN
    input  logic                  resp_err,
    output logic                  inst_fault,
`endif
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [XLEN-1:0]       inst_pc
);

    // Handshakes: a transfer happens on an edge where valid and ready are both high. req_valid,
    // once raised, holds with a stable req_addr until accepted; responses and pops are never refused.

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
`ifdef YSYX_22040175_IFU_FAULT_EN
    localparam int EW = XLEN + INST_WIDTH + 1;
`else
    localparam int EW = XLEN + INST_WIDTH;
`endif

    logic [XLEN-1:0]       fetch_pc;
    logic [CW-1:0]         discard;
    logic                  stale;
    logic                  halted;

    logic [XLEN-1:0]       pcq_head;
    logic [CW-1:0]         inflight;
    logic [EW-1:0]         inst_head;
    logic [EW-1:0]         inst_wdata;
    logic [CW-1:0]         inst_count;

    logic                  accept;
    logic                  hold;
    logic                  drop;
    logic                  push;
    logic                  pop;
    logic                  resp_bad;
    logic [INST_WIDTH-1:0] resp_word;
    logic [XLEN-1:0]       target;
    logic [CW-1:0]         inflight_d;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         discard_d;
    logic                  stale_d;
    logic                  halted_d;
    logic [XLEN-1:0]       fetch_pc_d;
    logic [XLEN-1:0]       req_addr_d;
    logic                  req_valid_d;

`ifdef YSYX_22040175_IFU_FAULT_EN
    assign resp_bad = resp_err;
`else
    assign resp_bad = 1'b0;
`endif

    assign accept    = req_valid && req_ready;
    assign hold      = req_valid && !req_ready;
    assign drop      = resp_valid && (discard != '0);
    assign push      = resp_valid && !drop && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign target    = redirect_pc & ~XLEN'(3);
    assign resp_word = resp_bad ? '0 : resp_data;

`ifdef YSYX_22040175_IFU_FAULT_EN
    assign inst_wdata = {pcq_head, resp_word, resp_bad};
    assign inst_fault = inst_head[0];
    assign inst       = inst_head[INST_WIDTH:1];
`else
    assign inst_wdata = {pcq_head, resp_word};
    assign inst       = inst_head[INST_WIDTH-1:0];
`endif
    assign inst_pc    = inst_head[EW-1 -: XLEN];
    assign inst_valid = (inst_count != '0);

    always_comb begin
        inflight_d = inflight + CW'(accept) - CW'(resp_valid);
        count_d    = redirect_valid ? '0 : inst_count + CW'(push) - CW'(pop);

        discard_d  = discard + CW'(accept && stale) - CW'(drop);
        stale_d    = accept ? 1'b0 : stale;
        halted_d   = (push && resp_bad) ? 1'b1 : halted;
        fetch_pc_d = (accept && !stale) ? fetch_pc + XLEN'(4) : fetch_pc;

        // Everything still outstanding after this edge belongs to the old stream.
        if (redirect_valid) begin
            discard_d  = inflight_d;
            stale_d    = hold;
            halted_d   = 1'b0;
            fetch_pc_d = target;
        end

        req_addr_d  = hold ? req_addr : fetch_pc_d;
        req_valid_d = hold ||
                      (!halted_d && (({1'b0, inflight_d} + {1'b0, count_d}) < DEPTH_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid <= 1'b0;
            req_addr  <= RESET_PC;
            fetch_pc  <= RESET_PC;
            discard   <= '0;
            stale     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            req_valid <= req_valid_d;
            req_addr  <= req_addr_d;
            fetch_pc  <= fetch_pc_d;
            discard   <= discard_d;
            stale     <= stale_d;
            halted    <= halted_d;
        end
    end

    // The PC queue pairs each in-order response with its address; its occupancy is the in-flight count.
    ysyx_22040175_ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (accept),
        .wdata (req_addr),
        .pop   (resp_valid),
        .rdata (pcq_head),
        .count (inflight)
    );

    ysyx_22040175_ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata (inst_wdata),
        .pop   (pop),
        .rdata (inst_head),
        .count (inst_count)
    );

endmodule
